// File: rtl/parallel_to_serial.sv
// rtl/parallel_to_serial.sv - parallel-in serial-out transmitter with one-word holding buffer
module parallel_to_serial #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] p_i,
    input  logic             p_valid,
    output logic             p_ready,
    output logic             serial_out,
    output logic             s_valid,
    output logic             s_last,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shifted;
    logic [WIDTH-1:0] hbuf;
    logic             hold_full;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last_bit;

    assign accept   = p_valid && !hold_full;
    assign last_bit = (state == SHIFT) && (cnt == LAST);

    // Move sreg one place toward the output end, zero-filling behind it.
    always_comb begin
        sreg_shifted = '0;
        if (MSB_FIRST) begin
            sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
        end else begin
            sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave SHIFT only when the last bit has no follow-on word.
    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (accept) begin
                state_nxt = SHIFT;
            end
        end else begin
            if (last_bit && !hold_full && !accept) begin
                state_nxt = IDLE;
            end
        end
    end

    // Outputs are derived from registers only; nothing flows from p_valid or p_i.
    always_comb begin
        p_ready    = !hold_full;
        s_valid    = (state == SHIFT);
        s_last     = last_bit;
        busy       = (state == SHIFT) || hold_full;
        serial_out = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    end

    // Datapath: shift register, bit counter and holding buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= '0;
            hbuf      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                sreg <= p_i;
                cnt  <= '0;
            end
        end else if (!last_bit) begin
            sreg <= sreg_shifted;
            cnt  <= cnt + CW'(1);
            if (accept) begin
                hbuf      <= p_i;
                hold_full <= 1'b1;
            end
        end else if (hold_full) begin
            sreg      <= hbuf;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            sreg <= p_i;
            cnt  <= '0;
        end else begin
            // Final shift empties sreg so the idle line sits at 0.
            sreg <= sreg_shifted;
            cnt  <= '0;
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb/tb_parallel_to_serial.sv - directed and loopback checks for parallel_to_serial
module tb_parallel_to_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] p_i = 8'h00;
    logic       p_valid = 1'b0;
    logic       p_ready;
    logic       serial_out;
    logic       s_valid;
    logic       s_last;
    logic       busy;

    logic [7:0] p_i1 = 8'h00;
    logic       p_valid1 = 1'b0;
    logic       p_ready1;
    logic       serial_out1;
    logic       s_valid1;
    logic       s_last1;
    logic       busy1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    parallel_to_serial #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .p_i(p_i), .p_valid(p_valid), .p_ready(p_ready),
        .serial_out(serial_out), .s_valid(s_valid), .s_last(s_last), .busy(busy)
    );

    parallel_to_serial #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .p_i(p_i1), .p_valid(p_valid1), .p_ready(p_ready1),
        .serial_out(serial_out1), .s_valid(s_valid1), .s_last(s_last1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp16;
        logic [7:0]  rx;
        logic [7:0]  q[$];
        logic        saw_valid;
        int          sent;
        int          received;
        int          budget;

        // Reset state, checked while rst_n is held low
        #12;
        chk("rst_serial_out", 32'(serial_out), 32'd0);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_s_last", 32'(s_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_p_ready", 32'(p_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Single word 0xA5, accepted at edge 0
        p_i = 8'hA5;
        p_valid = 1'b1;
        tick();
        p_valid = 1'b0;
        p_i = 8'h00;
        exp16 = 16'hA500;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("single_bit%0d", c), 32'(serial_out), 32'(exp16[16-c]));
            chk($sformatf("single_valid%0d", c), 32'(s_valid), 32'd1);
            chk($sformatf("single_last%0d", c), 32'(s_last), 32'(c == 8));
            tick();
        end
        chk("single_idle_valid", 32'(s_valid), 32'd0);
        chk("single_idle_out", 32'(serial_out), 32'd0);
        chk("single_idle_busy", 32'(busy), 32'd0);
        tick();

        // Back-to-back 0x3C then 0xC3 through the holding buffer
        p_i = 8'h3C;
        p_valid = 1'b1;
        tick();
        exp16 = 16'h3CC3;
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("b2b_bit%0d", c), 32'(serial_out), 32'(exp16[16-c]));
            chk($sformatf("b2b_valid%0d", c), 32'(s_valid), 32'd1);
            chk($sformatf("b2b_last%0d", c), 32'(s_last), 32'(c == 8 || c == 16));
            chk($sformatf("b2b_ready%0d", c), 32'(p_ready), 32'(!(c >= 2 && c <= 8)));
            if (c == 1) p_i = 8'hC3;
            if (c == 2) p_valid = 1'b0;
            tick();
        end
        chk("b2b_idle_valid", 32'(s_valid), 32'd0);
        tick();

        // Bypass: 0xFF offered only during the last bit of 0x01
        p_i = 8'h01;
        p_valid = 1'b1;
        tick();
        p_valid = 1'b0;
        exp16 = 16'h01FF;
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("byp_bit%0d", c), 32'(serial_out), 32'(exp16[16-c]));
            chk($sformatf("byp_valid%0d", c), 32'(s_valid), 32'd1);
            if (c == 9) chk("byp_ready9", 32'(p_ready), 32'd1);
            if (c == 8) begin
                p_i = 8'hFF;
                p_valid = 1'b1;
            end else begin
                p_valid = 1'b0;
            end
            tick();
        end
        chk("byp_idle_valid", 32'(s_valid), 32'd0);
        tick();

        // Reset during bit 4 of 0xF0 with 0x0F held
        p_i = 8'hF0;
        p_valid = 1'b1;
        tick();
        p_i = 8'h0F;
        tick();
        p_valid = 1'b0;
        tick();
        tick();
        chk("midrst_pre_busy", 32'(busy), 32'd1);
        chk("midrst_pre_ready", 32'(p_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_serial_out", 32'(serial_out), 32'd0);
        chk("midrst_s_valid", 32'(s_valid), 32'd0);
        chk("midrst_s_last", 32'(s_last), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_p_ready", 32'(p_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            saw_valid = saw_valid | s_valid | serial_out;
            tick();
        end
        chk("midrst_no_residue", 32'(saw_valid), 32'd0);
        chk("midrst_after_ready", 32'(p_ready), 32'd1);

        // LSB-first instance: 0x01 gives 1 then seven 0s
        p_i1 = 8'h01;
        p_valid1 = 1'b1;
        tick();
        p_valid1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("lsb_bit%0d", c), 32'(serial_out1), 32'(c == 1));
            chk($sformatf("lsb_last%0d", c), 32'(s_last1), 32'(c == 8));
            tick();
        end
        chk("lsb_idle_valid", 32'(s_valid1), 32'd0);

        // Loopback: 200 random words with random gaps, receiver shifts in at the LSB
        sent = 0;
        received = 0;
        rx = 8'h00;
        budget = 0;
        while ((sent < 200 || q.size() != 0) && budget < 5000) begin
            if (s_valid) begin
                rx = {rx[6:0], serial_out};
                if (s_last) begin
                    if (q.size() != 0) begin
                        chk($sformatf("loop_word%0d", received), 32'(rx), 32'(q.pop_front()));
                    end else begin
                        chk("loop_extra_word", 32'(q.size()), 32'd1);
                    end
                    received++;
                end
            end
            if (sent < 200) begin
                p_valid = ($urandom_range(0, 3) != 0);
                p_i = 8'($urandom);
            end else begin
                p_valid = 1'b0;
            end
            if (p_valid && p_ready) begin
                q.push_back(p_i);
                sent++;
            end
            tick();
            budget++;
        end
        p_valid = 1'b0;
        chk("loop_received", 32'(received), 32'd200);
        chk("loop_in_budget", 32'(budget < 5000), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
